// File: rtl/alu_request_driver.sv
// Buffers ALU requests in a FIFO and returns registered results over valid/ready.
// Latency: 1 cycle minimum from request acceptance to rsp_valid.
// Backpressure: a stalled response holds its slot, and the FIFO fills until req_ready drops.
package ALUOpcode;
    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        MUL = 4'd2,
        AND = 4'd3,
        OR  = 4'd4,
        XOR = 4'd5,
        EQ  = 4'd6,
        LT  = 4'd7
    } t_e;
endpackage

module alu_request_driver #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  ALUOpcode::t_e       req_opcode,
    input  logic signed [31:0]  req_a,
    input  logic signed [31:0]  req_b,
    output logic signed [31:0]  alu_a,
    output logic signed [31:0]  alu_b,
    output ALUOpcode::t_e       alu_opcode,
    input  logic signed [31:0]  alu_y,
    input  logic                alu_zero,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic signed [31:0]  rsp_y,
    output logic                rsp_zero,
    output logic                busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        ALUOpcode::t_e      opcode;
        logic signed [31:0] a;
        logic signed [31:0] b;
    } req_t;

    req_t              mem_q [DEPTH];
    req_t              req_in;
    req_t              head;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic signed [31:0] rsp_y_q, rsp_y_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              empty;
    logic              push;
    logic              pop;

    always_comb begin
        req_in.opcode = req_opcode;
        req_in.a      = req_a;
        req_in.b      = req_b;
        head          = mem_q[rptr_q];

        empty     = (count_q == '0);
        // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot early.
        req_ready = (count_q != CW'(DEPTH));
        push      = req_valid && req_ready;
        pop       = !empty && (!rsp_valid_q || rsp_ready);

        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_zero_d  = rsp_zero_q;
        if (pop) begin
            rsp_valid_d = 1'b1;
            rsp_y_d     = alu_y;
            rsp_zero_d  = alu_zero;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        // An idle ALU still sees a legal opcode.
        alu_opcode = ALUOpcode::ADD;
        alu_a      = '0;
        alu_b      = '0;
        if (!empty) begin
            alu_opcode = head.opcode;
            alu_a      = head.a;
            alu_b      = head.b;
        end

        rsp_valid = rsp_valid_q;
        rsp_y     = rsp_y_q;
        rsp_zero  = rsp_zero_q;
        busy      = !empty || rsp_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= req_in;
        end
    end

endmodule

// File: tb/tb_alu_request_driver.sv
// Scoreboard bench for alu_request_driver with a behavioural ALU model.
// Request acceptances push expected results; a monitor pops and compares on every response handshake.
module tb_alu_request_driver;
    import ALUOpcode::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    t_e                 req_opcode;
    logic signed [31:0] req_a, req_b;
    logic signed [31:0] alu_a, alu_b;
    t_e                 alu_opcode;
    logic signed [31:0] alu_y;
    logic               alu_zero;
    logic               rsp_valid;
    logic               rsp_ready;
    logic signed [31:0] rsp_y;
    logic               rsp_zero;
    logic               busy;

    typedef struct packed {
        logic [31:0] y;
        logic        z;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_y_in;
    logic        exp_z_in;
    int          errors = 0;
    int          checks = 0;
    int          acc_cnt = 0;
    int          rsp_cnt = 0;
    logic        rand_en = 1'b0;
    logic        stalled = 1'b0;
    logic [31:0] held_y;
    logic        held_z;

    alu_request_driver #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_y(alu_y), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_opcode)
            ADD:     alu_y = alu_a + alu_b;
            SUB:     alu_y = alu_a - alu_b;
            MUL:     alu_y = alu_a * alu_b;
            AND:     alu_y = alu_a & alu_b;
            OR:      alu_y = alu_a | alu_b;
            XOR:     alu_y = alu_a ^ alu_b;
            EQ:      alu_y = {31'b0, alu_a == alu_b};
            LT:      alu_y = {31'b0, alu_a < alu_b};
            default: alu_y = '0;
        endcase
        alu_zero = (alu_y == 0);
    end

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stalled = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                exp_t e;
                e.y = exp_y_in;
                e.z = exp_z_in;
                sb.push_back(e);
                acc_cnt++;
            end
            if (rsp_valid) begin
                if (stalled) begin
                    check("rsp_stable", rsp_y == held_y && rsp_zero == held_z, rsp_y, held_y);
                end
                if (rsp_ready) begin
                    rsp_cnt++;
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 1'b0, rsp_y, 32'h0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rsp_y", rsp_y == e.y, rsp_y, e.y);
                        check("rsp_zero", rsp_zero == e.z, {31'b0, rsp_zero}, {31'b0, e.z});
                    end
                end
            end
            stalled = rsp_valid && !rsp_ready;
            held_y  = rsp_y;
            held_z  = rsp_zero;
        end
    end

    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input t_e op, input logic signed [31:0] a, input logic signed [31:0] b,
                        input logic [31:0] ey, input logic ez);
        int n;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        exp_y_in   = ey;
        exp_z_in   = ez;
        req_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("send_timeout", 1'b0, 32'h0, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, !busy, {31'b0, busy}, 32'h0);
        check({name, "_sb_empty"}, sb.size() == 0, sb.size(), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        rst        = 1'b1;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        req_opcode = ADD;
        req_a      = 0;
        req_b      = 0;
        exp_y_in   = 0;
        exp_z_in   = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", req_ready == 1'b1, {31'b0, req_ready}, 32'h1);
        check("rst_busy", busy == 1'b0, {31'b0, busy}, 32'h0);
        check("rst_rsp_valid", rsp_valid == 1'b0, {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_y", rsp_y == 0, rsp_y, 32'h0);
        check("rst_rsp_zero", rsp_zero == 1'b0, {31'b0, rsp_zero}, 32'h0);
        check("rst_alu_op", alu_opcode == ADD, 32'(alu_opcode), 32'(ADD));
        check("rst_alu_ab", alu_a == 0 && alu_b == 0, alu_a | alu_b, 32'h0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;

        // Single request, one-cycle latency
        send(ADD, 5, 7, 32'd12, 1'b0);
        @(negedge clk);
        check("lat_edge_n", rsp_valid == 1'b0 && busy == 1'b1, {30'b0, rsp_valid, busy}, 32'h1);
        @(negedge clk);
        check("lat_edge_n1", rsp_valid == 1'b1, {31'b0, rsp_valid}, 32'h1);
        wait_idle("idle_single");

        // Back-to-back stream, one response per cycle
        base = rsp_cnt;
        send(SUB, 3, 3, 32'h0, 1'b1);
        send(XOR, 32'hFF, 32'h0F, 32'hF0, 1'b0);
        send(MUL, -4, 6, 32'hFFFF_FFE8, 1'b0);
        send(EQ, 9, 9, 32'h1, 1'b0);
        check("stream_rate_mid", rsp_cnt - base == 2, rsp_cnt - base, 32'd2);
        repeat (2) @(negedge clk);
        #1;
        check("stream_rate_end", rsp_cnt - base == 4, rsp_cnt - base, 32'd4);
        wait_idle("idle_stream");

        // Backpressure: one response held plus four queued
        rsp_ready = 1'b0;
        base = acc_cnt;
        for (int i = 0; i < 5; i++) send(ADD, 10 * i, 1, 10 * i + 1, 1'b0);
        req_opcode = ADD; req_a = 50; req_b = 1; exp_y_in = 51; exp_z_in = 1'b0;
        req_valid  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("bp_full_ready", req_ready == 1'b0, {31'b0, req_ready}, 32'h0);
        check("bp_accepted", acc_cnt - base == 5, acc_cnt - base, 32'd5);
        check("bp_held_rsp", rsp_valid == 1'b1 && rsp_y == 1, rsp_y, 32'h1);
        // Pulse rsp_ready while full: the pop must not admit a push in the same cycle
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("pulse_no_push", acc_cnt - base == 5 && req_ready == 1'b0, acc_cnt - base, 32'd5);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        #1;
        check("pulse_ready_after", req_ready == 1'b1, {31'b0, req_ready}, 32'h1);
        check("pulse_push_next", acc_cnt - base == 6, acc_cnt - base, 32'd6);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("pulse_refull", req_ready == 1'b0, {31'b0, req_ready}, 32'h0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle("idle_bp");

        // Pointer wrap with random consumer stalls
        rand_en = 1'b1;
        for (int i = 0; i < 10; i++) send(ADD, i, 0, i, i == 0);
        @(negedge clk);
        rand_en = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle("idle_wrap");

        // Reset with queued work and a pending response
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(ADD, 100 + i, 0, 100 + i, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        check("mrst_rsp_valid", rsp_valid == 1'b0, {31'b0, rsp_valid}, 32'h0);
        check("mrst_busy", busy == 1'b0, {31'b0, busy}, 32'h0);
        check("mrst_req_ready", req_ready == 1'b1, {31'b0, req_ready}, 32'h1);
        check("mrst_alu_op", alu_opcode == ADD && alu_a == 0, alu_a, 32'h0);
        base = rsp_cnt;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("mrst_no_stale", rsp_cnt == base, rsp_cnt - base, 32'h0);
        check("final_sb_empty", sb.size() == 0, sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_request_driver.md
# alu_request_driver

Sequential initiator that sits in front of the combinational 32-bit ALU and turns it into a handshaked, buffered execution unit. Accepts operation requests (opcode, a, b) on a valid/ready channel and queues them in a small FIFO. Presents the head entry to the ALU's operand/opcode inputs and captures the ALU's `y` and `zero` into a registered response slot, which it returns on a second valid/ready channel. Used by multi-cycle and test sequencers that must stall without holding ALU inputs stable themselves.

## Interface
- `DEPTH`, default 4: request FIFO entries; power of two, ≥ 2.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept.
- `req_opcode`  in  `ALUOpcode::t_e`  requested operation.
- `req_a`, `req_b`  in  32 signed  operands.
- `alu_a`, `alu_b`  out  32 signed  to ALU operands.
- `alu_opcode`  out  `ALUOpcode::t_e`  to ALU opcode.
- `alu_y`  in  32 signed  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `rsp_valid`  out  1  response slot full.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_y`  out  32 signed  captured result.
- `rsp_zero`  out  1  captured zero flag.
- `busy`  out  1  FIFO non-empty or `rsp_valid`.

## Operation
- FIFO: `DEPTH` entries of {opcode, a, b}. Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy count ranges 0..DEPTH.
- `req_ready` = (count < DEPTH), decoded from registered count only; independent of `rsp_ready` and of same-cycle pops.
- Push: `req_valid && req_ready`. Entry written at wptr; wptr advances.
- ALU drive, combinational from FIFO head:
  - Non-empty: `alu_opcode/alu_a/alu_b` = head fields.
  - Empty: `ALUOpcode::ADD`, 0, 0. The ALU never sees an undefined opcode.
- Advance condition: FIFO non-empty and (`!rsp_valid || rsp_ready`). On advance:
  - head popped;
  - `rsp_y <= alu_y`, `rsp_zero <= alu_zero`, `rsp_valid <= 1`.
- Drain only: `rsp_valid && rsp_ready` with FIFO empty sets `rsp_valid <= 0`. `rsp_y`/`rsp_zero` hold their last values.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full FIFO with a pop in the same cycle: no push that cycle, because `req_ready` is already 0.
- Ordering: responses are returned strictly in request order. No reordering, no drops.
- `rsp_y`/`rsp_zero` are stable while `rsp_valid && !rsp_ready`.
- Opcodes are passed through unchecked. Arithmetic and width behaviour are defined entirely by the ALU (32-bit, wrap-around, low 32 bits of MUL).

## Timing
- Reset (`rst` high at an edge):
  - count = 0, pointers = 0.
  - `rsp_valid` = 0, `rsp_y` = 0, `rsp_zero` = 0.
  - Hence `req_ready` = 1, `busy` = 0, ALU driven with ADD/0/0.
- Reset mid-operation discards all queued requests and any pending response; nothing is emitted afterwards.
- Latency: a request accepted at edge N onto an empty FIFO with an empty response slot has `rsp_valid` = 1 after edge N+1. Minimum latency is 1 cycle, because data cannot bypass the FIFO.
- Throughput: with `rsp_ready` held 1 and `req_valid` held 1, one response per cycle, steady state.
- Backpressure: with `rsp_ready` = 0, one response is held and the FIFO fills. `req_ready` drops after DEPTH further accepted requests.
- `busy` is combinational from registered state.

## Test plan
- Reset then single request ADD, a=5, b=7 -> `rsp_valid` one cycle after acceptance, `rsp_y`=12, `rsp_zero`=0; then `busy`=0.
- Back-to-back stream: SUB 3-3, XOR 0xFF^0x0F, MUL -4*6, EQ 9==9, with `rsp_ready`=1 -> in-order responses 0/zero=1, 0xF0, -24, 1, one per cycle.
- Backpressure, DEPTH=4, `rsp_ready`=0, offer 6 requests -> 5 accepted (1 in response slot + 4 queued), `req_ready`=0. Raise `rsp_ready` -> all 5 responses returned in order, `rsp_y` stable while stalled.
- Full FIFO with `rsp_ready` pulsed and `req_valid`=1 in the same cycle -> no push that cycle. Push occurs the next cycle and the count never exceeds 4.
- Pointer wrap: 10 sequential ADD i+0 requests with random `rsp_ready` -> responses 0..9 in order, none lost or duplicated.
- Assert `rst` with 3 queued and a response pending -> next cycle `rsp_valid`=0, `busy`=0, `req_ready`=1, no stale responses afterwards.
